// File: rtl/ledshift_param.sv
// LED pattern shifter: rotates/bounces a WIDTH-bit pattern every STEP_DIV clocks while running.
// All outputs registered (one-clock response to start/stop); no backpressure, strobes are level-sampled.
module ledshift_param #(
    parameter int                 WIDTH    = 8,
    parameter int                 STEP_DIV = 1000000,
    parameter logic [WIDTH-1:0]   INIT     = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_led,
    output logic             o_running,
    output logic             o_wrap
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_ROL  = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    state_t           state, state_nxt;
    dir_t             dir, dir_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] led, led_nxt;
    logic             wrap, wrap_nxt;
    logic             step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dir   <= DIR_LEFT;
            cnt   <= '0;
            led   <= INIT;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            cnt   <= cnt_nxt;
            led   <= led_nxt;
            wrap  <= wrap_nxt;
        end
    end

    assign step = (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        led_nxt   = led;
        wrap_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_nxt = RUN;
                    led_nxt   = INIT;
                    cnt_nxt   = '0;
                    dir_nxt   = DIR_LEFT;
                end
            end

            RUN: begin
                // Stop beats both restart and a pending step on the same edge.
                if (i_stop) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (i_start) begin
                    led_nxt = INIT;
                    cnt_nxt = '0;
                    dir_nxt = DIR_LEFT;
                end else if (step) begin
                    cnt_nxt = '0;
                    case (i_mode)
                        MODE_ROL: begin
                            led_nxt  = {led[WIDTH-2:0], led[WIDTH-1]};
                            wrap_nxt = led[WIDTH-1];
                        end
                        MODE_ROR: begin
                            led_nxt  = {led[0], led[WIDTH-1:1]};
                            wrap_nxt = led[0];
                        end
                        MODE_PING: begin
                            if (dir == DIR_LEFT) begin
                                if (led[WIDTH-1]) begin
                                    dir_nxt  = DIR_RIGHT;
                                    led_nxt  = led >> 1;
                                    wrap_nxt = 1'b1;
                                end else begin
                                    led_nxt = led << 1;
                                end
                            end else begin
                                if (led[0]) begin
                                    dir_nxt  = DIR_LEFT;
                                    led_nxt  = led << 1;
                                    wrap_nxt = 1'b1;
                                end else begin
                                    led_nxt = led >> 1;
                                end
                            end
                        end
                        default: begin
                            led_nxt = led;
                        end
                    endcase
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_led     = led;
    assign o_running = (state == RUN);
    assign o_wrap    = wrap;

endmodule

// File: tb/tb_ledshift_param.sv
// Directed bench for ledshift_param with WIDTH=8, STEP_DIV=4, INIT=8'h01.
module tb_ledshift_param;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_stop;
    logic [1:0] i_mode;
    logic [7:0] o_led;
    logic       o_running;
    logic       o_wrap;

    int n_checks = 0;
    int n_fails  = 0;

    ledshift_param #(
        .WIDTH    (8),
        .STEP_DIV (4),
        .INIT     (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_mode    (i_mode),
        .o_led     (o_led),
        .o_running (o_running),
        .o_wrap    (o_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three quiet edges then a step edge, measured from the previous step/start edge.
    task automatic run_step(input string tag, input logic [7:0] exp_led, input logic exp_wrap);
        logic [7:0] prev;
        prev = o_led;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_hold"}, o_led, prev);
            chk({tag, "_nowrap"}, {7'b0, o_wrap}, 8'h00);
        end
        tick();
        chk({tag, "_led"}, o_led, exp_led);
        chk({tag, "_wrap"}, {7'b0, o_wrap}, {7'b0, exp_wrap});
    endtask

    logic [7:0] rol_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] pp_exp [20] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04,
                                8'h08, 8'h10, 8'h20, 8'h40};

    initial begin
        rst     = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_mode  = 2'b00;

        // Reset state, then idle without start
        #23;
        chk("rst_led", o_led, 8'h01);
        chk("rst_running", {7'b0, o_running}, 8'h00);
        chk("rst_wrap", {7'b0, o_wrap}, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_led", o_led, 8'h01);
            chk("idle_running", {7'b0, o_running}, 8'h00);
            chk("idle_wrap", {7'b0, o_wrap}, 8'h00);
        end

        // Rotate left full circle
        i_mode  = 2'b00;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("rol_start_running", {7'b0, o_running}, 8'h01);
        chk("rol_start_led", o_led, 8'h01);
        for (int k = 0; k < 8; k++)
            run_step("rol", rol_exp[k], (k == 7));

        // Ping-pong, restarted from RUN
        i_mode  = 2'b10;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("pp_start_led", o_led, 8'h01);
        chk("pp_start_running", {7'b0, o_running}, 8'h01);
        for (int k = 0; k < 20; k++)
            run_step("pp", pp_exp[k], (k == 7) || (k == 14));

        // Stop on the edge where a step would have occurred
        i_mode  = 2'b00;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        run_step("ss_a", 8'h02, 1'b0);
        run_step("ss_b", 8'h04, 1'b0);
        run_step("ss_c", 8'h08, 1'b0);
        tick();
        tick();
        tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("stop_led", o_led, 8'h08);
        chk("stop_running", {7'b0, o_running}, 8'h00);
        chk("stop_wrap", {7'b0, o_wrap}, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stopped_led", o_led, 8'h08);
        end
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("both_running", {7'b0, o_running}, 8'h00);
        chk("both_led", o_led, 8'h08);
        tick();
        chk("both_after_running", {7'b0, o_running}, 8'h00);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("restart_led", o_led, 8'h01);
        chk("restart_running", {7'b0, o_running}, 8'h01);
        run_step("restart", 8'h02, 1'b0);

        // Hold mode, then switch to rotate right between steps
        run_step("mh_a", 8'h04, 1'b0);
        run_step("mh_b", 8'h08, 1'b0);
        run_step("mh_c", 8'h10, 1'b0);
        i_mode = 2'b11;
        run_step("hold_a", 8'h10, 1'b0);
        run_step("hold_b", 8'h10, 1'b0);
        tick();
        chk("sw_led_a", o_led, 8'h10);
        i_mode = 2'b01;
        tick();
        tick();
        chk("sw_led_b", o_led, 8'h10);
        tick();
        chk("sw_step_led", o_led, 8'h08);
        chk("sw_step_wrap", {7'b0, o_wrap}, 8'h00);
        run_step("ror_a", 8'h04, 1'b0);
        run_step("ror_b", 8'h02, 1'b0);
        run_step("ror_c", 8'h01, 1'b0);
        run_step("ror_d", 8'h80, 1'b1);
        run_step("ror_e", 8'h40, 1'b0);
        run_step("ror_f", 8'h20, 1'b0);

        // Asynchronous reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        chk("arst_led", o_led, 8'h01);
        chk("arst_running", {7'b0, o_running}, 8'h00);
        chk("arst_wrap", {7'b0, o_wrap}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ledshift_param.md
# ledshift_param

Parametrised LED pattern shifter, the successor to the fixed 8-bit LED shift block. It moves a WIDTH-bit pattern across the LED outputs at a programmable step rate set by an internal prescaler. It supports rotate-left, rotate-right, ping-pong and hold modes, with start/stop control and a wrap/bounce indicator. It sits between the board clock/reset and the LED pins, driven by push-button or controller start/stop strobes.

## Interface
- WIDTH, 8: pattern and LED width; legal range ≥ 2.
- STEP_DIV, 1000000: clock cycles per pattern step; legal range ≥ 1.
- INIT, {{(WIDTH-1){1'b0}},1'b1}: pattern loaded at reset and on (re)start.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  start/restart strobe, level-sampled each clock.
- i_stop  in  1  stop strobe, level-sampled each clock.
- i_mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 hold.
- o_led  out  WIDTH  current pattern.
- o_running  out  1  high while in RUN.
- o_wrap  out  1  one-cycle pulse on a wrap or bounce step.

## Operation
- State machine has two states, IDLE and RUN. Reset → IDLE.
- Reset values:
  - o_led = INIT
  - o_running = 0
  - o_wrap = 0
  - prescaler cnt = 0
  - direction dir = LEFT
- IDLE + i_start=1 (i_stop=0) → RUN. o_led loads INIT, cnt=0, dir=LEFT.
- RUN + i_stop=1 → IDLE. o_led freezes at its current value, cnt=0, and o_wrap is forced to 0 on that edge.
- RUN + i_start=1 (i_stop=0) restarts: o_led=INIT, cnt=0, dir=LEFT. The state stays RUN.
- i_start and i_stop both high: stop wins in both states.
- IDLE + i_stop: no effect.
- Prescaler, in RUN only:
  - cnt counts 0..STEP_DIV-1.
  - When cnt==STEP_DIV-1 a step occurs and cnt wraps to 0.
  - cnt width is clog2(STEP_DIV) with a minimum of 1.
  - STEP_DIV=1 gives a step every clock.
- i_mode is sampled only on step cycles, so a mode change between steps takes effect at the next step.
- Step actions, where P = o_led before the step:
  - 00: o_led = {P[WIDTH-2:0], P[WIDTH-1]}. o_wrap=1 iff P[WIDTH-1]=1.
  - 01: o_led = {P[0], P[WIDTH-1:1]}. o_wrap=1 iff P[0]=1.
  - 10, dir=LEFT:
    - If P[WIDTH-1]=1: dir←RIGHT, o_led = P>>1 (zero fill), o_wrap=1.
    - Else: o_led = P<<1 (zero fill).
  - 10, dir=RIGHT: mirror image of dir=LEFT, with P[0] as the bounce bit and P<<1 on bounce.
  - 11: o_led unchanged, o_wrap=0. The prescaler keeps running.
- The zero fill in ping-pong never loses the set bits of a single-bit pattern. Multi-bit patterns may shed bits at the edges; this is accepted.
- dir changes only in mode 10 and persists across mode switches until restart or reset.
- o_wrap is 0 on every non-step cycle.

## Timing
- Fully synchronous except rst.
- Reset assertion clears all state immediately. Release is sampled on the next clk edge; the block then idles until an i_start.
- i_start high at edge N:
  - o_running=1 and o_led=INIT after edge N.
  - First step at edge N+STEP_DIV, with o_led and o_wrap updating together.
  - Steps then repeat every STEP_DIV edges.
- i_stop high at edge M: o_running=0 after edge M, and no step occurs at edge M even if cnt==STEP_DIV-1.
- Outputs are registered; no combinational path exists from inputs to outputs.
- Reset asserted mid-RUN: all outputs return to reset values asynchronously, and no partial step occurs.

## Test plan
Parameters for all cases: WIDTH=8, STEP_DIV=4, INIT=8'h01.
- **Reset.** Hold rst=0, then release. Require o_led=8'h01, o_running=0, o_wrap=0, and no change over 20 cycles without i_start.
- **Rotate left.** Mode 00, pulse i_start.
  - Require o_led 01→02→04…→80→01 at 4-cycle spacing.
  - Require a single o_wrap pulse on the 80→01 step.
  - Require the first step exactly 4 edges after the start edge.
- **Ping-pong.** Mode 10, run 20 steps.
  - Require 01,02,…,80,40,…,01,02.
  - Require o_wrap pulses on the 80→40 and 01→02 steps only.
- **Stop/start priority.**
  - Stop mid-run at o_led=08: require o_led to hold 08 and o_running=0.
  - Assert i_start and i_stop together: require the block to stay IDLE.
  - Then i_start alone: require o_led=01 with the step counter restarted.
- **Mode change and hold.**
  - Switch 00→11 at o_led=10: require o_led to stay 10.
  - Switch 11→01: require the next step to give 08, aligned to the free-running prescaler.
- **Async reset mid-run.** Drop rst at a non-edge time with o_led=20. Require o_led=01 and o_running=0 before the next clk edge.
